// File: rtl/dm_resp.sv
// rtl/dm_resp.sv - data-memory responder with fixed wait states and one-cycle ack
// Optional byte write enables: define DM_BYTE_WR_EN to add the be port.
module dm_resp #(
  parameter int DEPTH_LOG2 = 10,
  parameter int WAIT_CYC   = 2
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        req,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
`ifdef DM_BYTE_WR_EN
  input  logic [3:0]  be,
`endif
  output logic [31:0] rdata,
  output logic        ack,
  output logic        err,
  output logic        busy
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = (WAIT_CYC == 0) ? 4'd0 : 4'(WAIT_CYC - 1);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t                  state, state_nxt;
  logic [3:0]              cnt;
  logic                    lat_we;
  logic [DEPTH_LOG2-1:0]   lat_idx;
  logic [1:0]              lat_off;
  logic [31:0]             lat_wdata;
`ifdef DM_BYTE_WR_EN
  logic [3:0]              lat_be;
`endif
  logic [31:0]             mem [DEPTH];
  logic [31:0]             rdata_q;

  logic                    rd_we;
  logic [DEPTH_LOG2-1:0]   rd_idx;
  logic [1:0]              rd_off;
  logic                    rd_ok;
  logic                    unused_addr_hi;

  assign unused_addr_hi = ^addr[31:DEPTH_LOG2+2];

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (req) state_nxt = (WAIT_CYC == 0) ? S_RESP : S_WAIT;
      S_WAIT: if (cnt == 4'd0) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // With no wait states the RAM read happens on the accepting edge, so use the live request.
  always_comb begin
    rd_we  = lat_we;
    rd_idx = lat_idx;
    rd_off = lat_off;
    if (state == S_IDLE) begin
      rd_we  = we;
      rd_idx = addr[DEPTH_LOG2+1:2];
      rd_off = addr[1:0];
    end
    rd_ok = !rd_we && (rd_off == 2'd0);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt       <= 4'd0;
      lat_we    <= 1'b0;
      lat_idx   <= '0;
      lat_off   <= 2'd0;
      lat_wdata <= 32'd0;
`ifdef DM_BYTE_WR_EN
      lat_be    <= 4'd0;
`endif
      rdata_q   <= 32'd0;
    end else begin
      if (state == S_IDLE && req) begin
        cnt       <= CNT_INIT;
        lat_we    <= we;
        lat_idx   <= addr[DEPTH_LOG2+1:2];
        lat_off   <= addr[1:0];
        lat_wdata <= wdata;
`ifdef DM_BYTE_WR_EN
        lat_be    <= be;
`endif
      end else if (state == S_WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (state_nxt == S_RESP && state != S_RESP && rd_ok) rdata_q <= mem[rd_idx];
      else                                                  rdata_q <= 32'd0;
    end
  end

  // Store commits on the edge leaving RESP; a reset forces IDLE and so cancels it.
  always_ff @(posedge clk) begin
    if (state == S_RESP && lat_we && lat_off == 2'd0) begin
`ifdef DM_BYTE_WR_EN
      for (int i = 0; i < 4; i++)
        if (lat_be[i]) mem[lat_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
`else
      mem[lat_idx] <= lat_wdata;
`endif
    end
  end

  assign ack   = (state == S_RESP);
  assign busy  = (state != S_IDLE);
  assign err   = ack && (lat_off != 2'd0);
  assign rdata = rdata_q;

endmodule

// File: tb/tb_dm_resp.sv
// tb/tb_dm_resp.sv - self-checking bench for dm_resp against a transaction-level model
module tb_dm_resp;

  localparam int W = 2;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        req = 1'b0;
  logic        req0 = 1'b0;
  logic        we = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [3:0]  be = 4'hF;
  logic [31:0] rdata, rdata0;
  logic        ack, err, busy, ack0, err0, busy0;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  dm_resp #(.DEPTH_LOG2(10), .WAIT_CYC(W)) u_dut (
    .clk(clk), .clr(clr), .req(req), .we(we), .addr(addr), .wdata(wdata),
`ifdef DM_BYTE_WR_EN
    .be(be),
`endif
    .rdata(rdata), .ack(ack), .err(err), .busy(busy)
  );

  dm_resp #(.DEPTH_LOG2(10), .WAIT_CYC(0)) u_dut0 (
    .clk(clk), .clr(clr), .req(req0), .we(we), .addr(addr), .wdata(wdata),
`ifdef DM_BYTE_WR_EN
    .be(be),
`endif
    .rdata(rdata0), .ack(ack0), .err(err0), .busy(busy0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = b[i] ? n[8*i +: 8] : o[8*i +: 8];
    return r;
  endfunction

  // Transaction-level model: accept time, ack at accept+W, commit when leaving the ack cycle.
  logic [31:0] mmem [1024];
  bit          mvalid [1024];
  int          edge_n = 0;
  int          acc_e = 0;
  bit          m_active = 1'b0;
  bit          m_we = 1'b0;
  logic [31:0] m_addr = 32'd0;
  logic [31:0] m_wdata = 32'd0;
  logic [3:0]  m_be = 4'hF;

  always @(posedge clk) begin
    edge_n++;
    if (clr) begin
      if (m_active) begin
        if (edge_n == acc_e + W + 1) begin
          if (m_we && m_addr[1:0] == 2'd0) begin
            mmem[m_addr[11:2]] = merge(mmem[m_addr[11:2]], m_wdata, m_be);
            if (m_be == 4'hF) mvalid[m_addr[11:2]] = 1'b1;
          end
          m_active = 1'b0;
        end
      end else if (req) begin
        m_active = 1'b1;
        acc_e    = edge_n;
        m_we     = we;
        m_addr   = addr;
        m_wdata  = wdata;
`ifdef DM_BYTE_WR_EN
        m_be     = be;
`else
        m_be     = 4'hF;
`endif
      end
    end
  end

  always @(negedge clr) m_active = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      logic        e_ack;
      logic        e_ld;
      logic [31:0] e_rd;
      e_ack = m_active && (edge_n == acc_e + W);
      e_ld  = e_ack && !m_we && (m_addr[1:0] == 2'd0);
      e_rd  = e_ld ? mmem[m_addr[11:2]] : 32'd0;
      check("m_ack", {31'd0, ack}, {31'd0, e_ack});
      check("m_busy", {31'd0, busy}, {31'd0, m_active});
      check("m_err", {31'd0, err}, {31'd0, e_ack && (m_addr[1:0] != 2'd0)});
      if (!(e_ld && !mvalid[m_addr[11:2]])) check("m_rdata", rdata, e_rd);
    end
  end

  task automatic txn(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                     output logic [31:0] rd, output logic e, output int lat);
    @(negedge clk);
    req = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(negedge clk);
    req = 1'b0; we = ~w; addr = ~a; wdata = ~d; be = ~b;
    check("busy_c1", {31'd0, busy}, 32'd1);
    lat = 1;
    while (!ack && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!ack) check("ack_timeout", 32'd0, 32'd1);
    rd = rdata;
    e  = err;
    @(negedge clk);
  endtask

  task automatic txn0(input bit w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] b,
                      output logic [31:0] rd, output int lat);
    @(negedge clk);
    req0 = 1'b1; we = w; addr = a; wdata = d; be = b;
    @(negedge clk);
    req0 = 1'b0; we = ~w; addr = ~a; wdata = ~d; be = ~b;
    lat = 1;
    while (!ack0 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    if (!ack0) check("ack0_timeout", 32'd0, 32'd1);
    check("busy0_ack", {31'd0, busy0}, 32'd1);
    check("err0", {31'd0, err0}, 32'd0);
    rd = rdata0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    int          lat;
    int          acks[$];
    int          n;

    #1 clr = 1'b0;
    #3;
    check("rst_ack", {31'd0, ack}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_err", {31'd0, err}, 32'd0);
    check("rst_rdata", rdata, 32'd0);
    chk_en = 1'b1;
    @(negedge clk); @(negedge clk);
    clr = 1'b1;

    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, rd, e, lat);
    check("st_lat", lat, 32'd3);
    check("st_err", {31'd0, e}, 32'd0);
    check("st_rdata", rd, 32'd0);
    txn(1'b0, 32'h10, 32'h0, 4'hF, rd, e, lat);
    check("ld_lat", lat, 32'd3);
    check("ld_10", rd, 32'hDEADBEEF);

    txn(1'b1, 32'h10, 32'h12345678, 4'hF, rd, e, lat);
    txn(1'b0, 32'h12, 32'h0, 4'hF, rd, e, lat);
    check("mis_ld_err", {31'd0, e}, 32'd1);
    check("mis_ld_rdata", rd, 32'd0);
    txn(1'b1, 32'h11, 32'hFFFFFFFF, 4'hF, rd, e, lat);
    check("mis_st_err", {31'd0, e}, 32'd1);
    txn(1'b0, 32'h10, 32'h0, 4'hF, rd, e, lat);
    check("ld_after_mis", rd, 32'h12345678);

    txn(1'b1, 32'h1004, 32'hA5A5A5A5, 4'hF, rd, e, lat);
    txn(1'b0, 32'h4, 32'h0, 4'hF, rd, e, lat);
    check("wrap_ld", rd, 32'hA5A5A5A5);
    check("wrap_err", {31'd0, e}, 32'd0);

    for (int k = 0; k < 8; k++) txn(1'b1, 32'h40 + 32'(4 * k), 32'(k), 4'hF, rd, e, lat);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h40; wdata = $urandom;
    for (int c = 0; c < 30; c++) begin
      if (c == 20) req = 1'b0;
      if (ack) acks.push_back(c);
      addr  = 32'h40 + 32'(4 * $urandom_range(0, 7));
      wdata = $urandom;
      @(negedge clk);
    end
    check("held_count", acks.size(), 32'd5);
    if (acks.size() > 0) check("held_first", acks[0], 32'd3);
    for (int i = 1; i < acks.size(); i++) check("held_spacing", acks[i] - acks[i-1], 32'd4);
    for (int k = 0; k < 8; k++) txn(1'b0, 32'h40 + 32'(4 * k), 32'h0, 4'hF, rd, e, lat);

    txn(1'b1, 32'h20, 32'h11111111, 4'hF, rd, e, lat);
    @(negedge clk);
    req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h55555555;
    @(negedge clk);
    req = 1'b0;
    check("busy_pre_rst", {31'd0, busy}, 32'd1);
    #2 clr = 1'b0;
    #1;
    check("arst_ack", {31'd0, ack}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_rdata", rdata, 32'd0);
    @(negedge clk); @(negedge clk);
    clr = 1'b1;
    n = 0;
    for (int c = 0; c < 6; c++) begin
      if (ack) n++;
      @(negedge clk);
    end
    check("no_ack_after_rst", n, 32'd0);
    txn(1'b0, 32'h20, 32'h0, 4'hF, rd, e, lat);
    check("ld_20_kept", rd, 32'h11111111);

    txn0(1'b1, 32'h8, 32'hCAFEF00D, 4'hF, rd, lat);
    check("w0_st_lat", lat, 32'd1);
    txn0(1'b0, 32'h8, 32'h0, 4'hF, rd, lat);
    check("w0_ld_lat", lat, 32'd1);
    check("w0_ld", rd, 32'hCAFEF00D);

`ifdef DM_BYTE_WR_EN
    txn(1'b1, 32'h30, 32'h11223344, 4'b1111, rd, e, lat);
    txn(1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, rd, e, lat);
    txn(1'b0, 32'h30, 32'h0, 4'b0000, rd, e, lat);
    check("be_ld", rd, 32'h11BB33DD);
    txn(1'b1, 32'h30, 32'hFFFFFFFF, 4'b0000, rd, e, lat);
    check("be0_err", {31'd0, e}, 32'd0);
    txn(1'b0, 32'h30, 32'h0, 4'b0000, rd, e, lat);
    check("be0_ld", rd, 32'h11BB33DD);
    txn0(1'b1, 32'h30, 32'h11223344, 4'b1111, rd, lat);
    txn0(1'b1, 32'h30, 32'hAABBCCDD, 4'b0101, rd, lat);
    check("w0_be_lat", lat, 32'd1);
    txn0(1'b0, 32'h30, 32'h0, 4'b0000, rd, lat);
    check("w0_be_ld", rd, 32'h11BB33DD);
`endif

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
